sdram_bist: RTL and testbench
=============================

SDRAM_BIST -- requirements
Module: sdram_bist

Interface
REQ-001 Parameters SHALL be, one per line:
- BURST_LEN, 8, words per command, legal range 1..256.
- ADDR_START, 25'h0000000, first word address tested.
- ADDR_END, 25'h00000FF, last word address tested; ADDR_END-ADDR_START+1 is a multiple of BURST_LEN.
- SEED, 16'hACE1, LFSR seed, nonzero.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; controller user-side clock.
- rst_n  in  1  asynchronous active-low reset; driven by the controller init-done flag.
- start  in  1  one-cycle pulse; begins a test run.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  done with err_cnt==0.
- err_cnt  out  16  mismatch count, saturating.
- first_err_adr  out  25  word address of the first mismatch.
- cmd_en  out  1  command strobe.
- cmd_wr_rd  out  1  0=write, 1=read.
- cmd_av  in  1  controller accepts a command.
- cmd_len  out  10  burst length.
- cmd_adr  out  25  word address.
- wr_remain_space  in  10  free entries in the write FIFO.
- wr_en  out  1  write-FIFO push.
- wr_data  out  16  push data.
- wr_mask  out  2  byte mask, always 2'b00.
- rd_av  in  1  read FIFO non-empty.
- rd_en  out  1  read-FIFO pop.
- rd_data  in  16  valid in the same cycle as rd_en.

Function
REQ-003 Data pattern SHALL be a 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded with SEED at start; advanced once per word written; regenerated from SEED at the start of the read phase.
REQ-004 FSM states SHALL be IDLE, WFILL, WCMD, RCMD, RDRAIN, DONE.
REQ-005 IDLE->WFILL SHALL occur on start; busy=1; err_cnt cleared; burst address = ADDR_START.
REQ-006 WFILL SHALL wait until wr_remain_space>=BURST_LEN, then push BURST_LEN words on consecutive cycles with wr_en=1; then ->WCMD.
REQ-007 WCMD SHALL hold cmd_en=1, cmd_wr_rd=0, cmd_len=BURST_LEN, cmd_adr=burst address until a cycle with cmd_av=1; acceptance is cmd_en&&cmd_av.
REQ-008 After write acceptance: burst address += BURST_LEN; ->WFILL if the new address <=ADDR_END, else reset address to ADDR_START, reload LFSR, ->RCMD.
REQ-009 RCMD SHALL issue a read command with the same handshake as WCMD (cmd_wr_rd=1), then ->RDRAIN.
REQ-010 RDRAIN SHALL assert rd_en only when rd_av=1; each rd_en cycle compares rd_data against the LFSR and advances the LFSR; after BURST_LEN pops, advance the address as in REQ-008, ->RCMD or ->DONE.
REQ-011 On mismatch, err_cnt SHALL increment, saturating at 16'hFFFF; on the first mismatch of a run, first_err_adr SHALL latch burst address + word index.
REQ-012 DONE SHALL drive busy=0, done=1, pass=(err_cnt==0); start in DONE SHALL clear done and pass and begin a new run.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 cmd_en, wr_en and rd_en SHALL never be high in the same cycle.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 rst_n low SHALL force, asynchronously, all outputs to 0 and the FSM to IDLE, including mid-burst; no partial burst resumes after release.

Configuration
REQ-017 With SDRAM_BIST_ERRINJ_EN defined, an input err_inj (1 bit) SHALL be sampled at start; when it is 1, the first word written in the run is XORed with 16'h0001.
REQ-018 Without SDRAM_BIST_ERRINJ_EN, the err_inj port and its logic SHALL be absent.

Verification
REQ-019 Ideal controller model, defaults, start pulse -> 32 write commands at 0x00,0x08,...,0xF8, then 32 reads; done=1, pass=1, err_cnt=0.
REQ-020 Model flips bit 3 of the read word at address 0x13 -> err_cnt=1, first_err_adr=25'h13, pass=0.
REQ-021 cmd_av held low 20 cycles on the second write command -> cmd_en held with cmd_adr=0x08 for 20 cycles; no duplicate command issued.
REQ-022 rd_av toggling 1/0 each cycle -> rd_en asserted only while rd_av=1; still pass=1.
REQ-023 rst_n pulsed low during the 5th write burst -> all outputs 0 immediately; new start completes with pass=1.
REQ-024 SDRAM_BIST_ERRINJ_EN defined, err_inj=1 at start -> err_cnt=1, first_err_adr=ADDR_START.

Source files
------------

// File: rtl/sdram_bist.sv
// sdram_bist: LFSR write/read-back self-test driving an SDRAM controller user port.
// Define SDRAM_BIST_ERRINJ_EN to add err_inj, which corrupts the first written word of a run.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   WFILL  | waiting for write-FIFO room, then pushing one burst
//   WCMD   | write command offered until accepted
//   RCMD   | read command offered until accepted
//   RDRAIN | popping and checking one burst of read data
//   DONE   | results held until the next start
module sdram_bist #(
    parameter int unsigned BURST_LEN  = 8,
    parameter logic [24:0] ADDR_START = 25'h0000000,
    parameter logic [24:0] ADDR_END   = 25'h00000FF,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef SDRAM_BIST_ERRINJ_EN
    input  logic        err_inj,
`endif
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [24:0] first_err_adr,
    output logic        cmd_en,
    output logic        cmd_wr_rd,
    input  logic        cmd_av,
    output logic [9:0]  cmd_len,
    output logic [24:0] cmd_adr,
    input  logic [9:0]  wr_remain_space,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic [1:0]  wr_mask,
    input  logic        rd_av,
    output logic        rd_en,
    input  logic [15:0] rd_data
);

    typedef enum logic [2:0] {IDLE, WFILL, WCMD, RCMD, RDRAIN, DONE} state_t;

    localparam logic [8:0]  BL_W    = 9'(BURST_LEN);
    localparam logic [9:0]  CMD_LEN = 10'(BURST_LEN);
    localparam logic [25:0] END_X   = {1'b0, ADDR_END};

    state_t      state, state_n;
    logic [24:0] adr, adr_n;
    logic [25:0] adr_inc;
    logic [8:0]  wcnt;
    logic [15:0] lfsr, lfsr_step, wr_word, err_cnt_n;
    logic        last_burst, accept, start_ok, push, pop_issue, pop_cmp, mismatch;
    logic        cmd_n, reload;

`ifdef SDRAM_BIST_ERRINJ_EN
    logic        inj;
    assign wr_word = lfsr ^ {15'b0, inj};
`else
    assign wr_word = lfsr;
`endif

    assign wr_mask    = 2'b00;
    assign lfsr_step  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign adr_inc    = {1'b0, adr} + 26'(BURST_LEN);
    assign last_burst = adr_inc > END_X;
    assign accept     = cmd_en && cmd_av;
    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign push       = (state == WFILL) && (wcnt < BL_W) &&
                        ((wcnt != 9'd0) || (wr_remain_space >= CMD_LEN));
    // rd_en is registered, so pop at most every other cycle: rd_av seen while idle
    // guarantees the FIFO still holds a word when the pop lands.
    assign pop_issue  = (state == RDRAIN) && (wcnt < BL_W) && rd_av && !rd_en;
    assign pop_cmp    = (state == RDRAIN) && rd_en;
    assign mismatch   = pop_cmp && (rd_data != lfsr);
    assign err_cnt_n  = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    assign reload     = (state == WCMD) && accept && last_burst;
    assign cmd_n      = (state_n == WCMD) || (state_n == RCMD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        adr_n   = adr;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = WFILL;
                    adr_n   = ADDR_START;
                end
            end
            WFILL: begin
                if (wcnt == BL_W) state_n = WCMD;
            end
            WCMD: begin
                if (accept) begin
                    if (last_burst) begin
                        state_n = RCMD;
                        adr_n   = ADDR_START;
                    end else begin
                        state_n = WFILL;
                        adr_n   = adr_inc[24:0];
                    end
                end
            end
            RCMD: begin
                if (accept) state_n = RDRAIN;
            end
            RDRAIN: begin
                if (pop_cmp && (wcnt == BL_W)) begin
                    if (last_burst) begin
                        state_n = DONE;
                    end else begin
                        state_n = RCMD;
                        adr_n   = adr_inc[24:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr           <= '0;
            wcnt          <= '0;
            lfsr          <= SEED;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_adr <= '0;
            cmd_en        <= 1'b0;
            cmd_wr_rd     <= 1'b0;
            cmd_len       <= '0;
            cmd_adr       <= '0;
            wr_en         <= 1'b0;
            wr_data       <= '0;
            rd_en         <= 1'b0;
`ifdef SDRAM_BIST_ERRINJ_EN
            inj           <= 1'b0;
`endif
        end else begin
            adr       <= adr_n;
            busy      <= (state_n != IDLE) && (state_n != DONE);
            done      <= (state_n == DONE);
            pass      <= (state_n == DONE) && (err_cnt_n == 16'd0);
            cmd_en    <= cmd_n;
            cmd_wr_rd <= (state_n == RCMD);
            cmd_len   <= cmd_n ? CMD_LEN : '0;
            cmd_adr   <= cmd_n ? adr_n : '0;
            wr_en     <= push;
            rd_en     <= pop_issue;
            err_cnt   <= err_cnt_n;
            if (mismatch && (err_cnt == 16'd0))
                first_err_adr <= adr + 25'(wcnt - 9'd1);
            if ((state_n != state) && ((state_n == WFILL) || (state_n == RDRAIN)))
                wcnt <= '0;
            else if (push || pop_issue)
                wcnt <= wcnt + 9'd1;
            if (push) wr_data <= wr_word;
            if (start_ok || reload)
                lfsr <= SEED;
            else if (push || pop_cmp)
                lfsr <= lfsr_step;
            if (start_ok) begin
                err_cnt       <= '0;
                first_err_adr <= '0;
            end
`ifdef SDRAM_BIST_ERRINJ_EN
            if (start_ok)  inj <= err_inj;
            else if (push) inj <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_bist.sv
// Scoreboard bench for sdram_bist: a behavioural SDRAM controller and memory answer the DUT,
// and a monitor checks commands, write data and run results against expected queues.
module tb_sdram_bist;
    localparam int BL = 8;
    localparam int A0 = 0;
    localparam int A1 = 'hFF;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int NW = A1 - A0 + 1;
    localparam int NB = NW / BL;

    localparam int M_IDEAL   = 0;
    localparam int M_STALL   = 1;
    localparam int M_TRICKLE = 2;
    localparam int M_RANDOM  = 3;

    typedef struct packed {
        logic        wr_rd;
        logic [24:0] adr;
        logic [9:0]  len;
    } cmd_t;

    typedef struct packed {
        logic [15:0] errs;
        logic        pass;
        logic [24:0] first;
        logic        chk_first;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n, start, cmd_av, rd_av;
    logic [9:0]  wr_remain_space;
    logic [15:0] rd_data;
    logic        busy, done, pass, cmd_en, cmd_wr_rd, wr_en, rd_en;
    logic [15:0] err_cnt, wr_data;
    logic [24:0] first_err_adr, cmd_adr;
    logic [9:0]  cmd_len;
    logic [1:0]  wr_mask;
`ifdef SDRAM_BIST_ERRINJ_EN
    logic        err_inj = 1'b0;
`endif

    always #5 clk = ~clk;

    sdram_bist #(
        .BURST_LEN (BL),
        .ADDR_START(25'(A0)),
        .ADDR_END  (25'(A1)),
        .SEED      (SEED)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
`ifdef SDRAM_BIST_ERRINJ_EN
        .err_inj        (err_inj),
`endif
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_adr  (first_err_adr),
        .cmd_en         (cmd_en),
        .cmd_wr_rd      (cmd_wr_rd),
        .cmd_av         (cmd_av),
        .cmd_len        (cmd_len),
        .cmd_adr        (cmd_adr),
        .wr_remain_space(wr_remain_space),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .rd_av          (rd_av),
        .rd_en          (rd_en),
        .rd_data        (rd_data)
    );

    cmd_t        exp_cmd[$];
    logic [15:0] exp_wd[$];
    res_t        exp_res[$];
    logic [15:0] wfifo[$], rfifo[$], rpend[$];
    logic [15:0] mem  [int];
    logic [15:0] flip [int];

    int   vectors = 0;
    int   miscompares = 0;
    int   mode = M_IDEAL;
    int   wr_cmds = 0;
    int   stall_cnt = 0;
    logic pop_pend = 1'b0;
    logic toggle_ph = 1'b0;
    logic done_seen = 1'b1;
    cmd_t        mon_cmd;
    res_t        mon_res;
    int          mon_a;
    logic [15:0] mon_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got an unexpected event, required none", name);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, done, pass, cmd_en, cmd_wr_rd, wr_en, rd_en, wr_mask, cmd_len}), 64'd0);
        check({tag, "_result"}, 64'({err_cnt, first_err_adr}), 64'd0);
        check({tag, "_bus"}, 64'({cmd_adr, wr_data}), 64'd0);
    endtask

    // Controller/memory model and monitor; everything here acts on values the DUT
    // will sample at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pop_pend && (rfifo.size() > 0)) void'(rfifo.pop_front());
            case (mode)
                M_TRICKLE: begin
                    toggle_ph = ~toggle_ph;
                    if (toggle_ph && (rpend.size() > 0)) rfifo.push_back(rpend.pop_front());
                end
                M_RANDOM: begin
                    if ((rpend.size() > 0) && ($urandom_range(0, 1) == 1)) rfifo.push_back(rpend.pop_front());
                end
                default: begin
                    while (rpend.size() > 0) rfifo.push_back(rpend.pop_front());
                end
            endcase
            rd_av   = (rfifo.size() > 0);
            rd_data = rd_av ? rfifo[0] : 16'($urandom);
            if (rd_en) check("rd_en_without_rd_av", 64'(rd_av), 64'd1);
            pop_pend = rd_en;

            if (cmd_en || wr_en || rd_en)
                check("strobe_exclusive", 64'(int'(cmd_en) + int'(wr_en) + int'(rd_en)), 64'd1);

            if (wr_en) begin
                check("wr_mask", 64'(wr_mask), 64'd0);
                if (exp_wd.size() == 0) fail_now("wr_data_extra");
                else check("wr_data", 64'(wr_data), 64'(exp_wd.pop_front()));
                wfifo.push_back(wr_data);
            end

            cmd_av = 1'b1;
            if (mode == M_RANDOM) begin
                cmd_av = ($urandom_range(0, 9) < 7);
            end else if ((mode == M_STALL) && cmd_en && !cmd_wr_rd && (wr_cmds == 1) && (stall_cnt < 20)) begin
                cmd_av = 1'b0;
                stall_cnt++;
                check("stall_cmd_held", 64'({cmd_en, cmd_adr}), 64'({1'b1, 25'h8}));
            end

            if (cmd_en && cmd_av) begin
                mon_cmd = {cmd_wr_rd, cmd_adr, cmd_len};
                if (exp_cmd.size() == 0) fail_now("cmd_extra");
                else check("cmd", 64'(mon_cmd), 64'(exp_cmd.pop_front()));
                if (!cmd_wr_rd) begin
                    if ((mode == M_STALL) && (wr_cmds == 1)) check("stall_cycles", 64'(stall_cnt), 64'd20);
                    wr_cmds++;
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        mon_a = int'(cmd_adr) + i;
                        mem[mon_a] = (wfifo.size() > 0) ? wfifo.pop_front() : 16'hDEAD;
                    end
                end else begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        mon_a = int'(cmd_adr) + i;
                        mon_w = mem.exists(mon_a) ? mem[mon_a] : 16'h0000;
                        if (flip.exists(mon_a)) mon_w = mon_w ^ flip[mon_a];
                        rpend.push_back(mon_w);
                    end
                end
            end

            wr_remain_space = (mode == M_RANDOM) ? 10'($urandom_range(0, 24)) : 10'd512;

            if (done && !done_seen) begin
                done_seen = 1'b1;
                if (exp_res.size() == 0) begin
                    fail_now("result_extra");
                end else begin
                    mon_res = exp_res.pop_front();
                    check("err_cnt", 64'(err_cnt), 64'(mon_res.errs));
                    check("pass", 64'(pass), 64'(mon_res.pass));
                    if (mon_res.chk_first) check("first_err_adr", 64'(first_err_adr), 64'(mon_res.first));
                end
            end
        end
    end

    task automatic flush_model();
        exp_cmd.delete();
        exp_wd.delete();
        exp_res.delete();
        wfifo.delete();
        rfifo.delete();
        rpend.delete();
        pop_pend = 1'b0;
        rd_av = 1'b0;
    endtask

    task automatic reset_flush();
        @(negedge clk);
        rst_n = 1'b0;
        flush_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic begin_run(input int m, input bit inj);
        logic [15:0] l;
        int          errs;
        logic [24:0] first;
        res_t        r;
        cmd_t        c;
        mode = m;
        stall_cnt = 0;
        wr_cmds = 0;
        toggle_ph = 1'b0;
        flush_model();
        l = SEED;
        for (int k = 0; k < NW; k++) begin
            exp_wd.push_back((inj && (k == 0)) ? (l ^ 16'h0001) : l);
            l = lfsr_next(l);
        end
        for (int b = 0; b < NB; b++) begin
            c = {1'b0, 25'(A0 + b * BL), 10'(BL)};
            exp_cmd.push_back(c);
        end
        for (int b = 0; b < NB; b++) begin
            c = {1'b1, 25'(A0 + b * BL), 10'(BL)};
            exp_cmd.push_back(c);
        end
        errs = 0;
        first = '0;
        for (int a = A0; a <= A1; a++) begin
            if ((inj && (a == A0)) || (flip.exists(a) && (flip[a] != 16'h0))) begin
                if (errs == 0) first = 25'(a);
                errs++;
            end
        end
        r.errs = 16'(errs);
        r.pass = (errs == 0);
        r.first = first;
        r.chk_first = (errs != 0);
        exp_res.push_back(r);
        @(negedge clk);
        start = 1'b1;
`ifdef SDRAM_BIST_ERRINJ_EN
        err_inj = inj;
`endif
        @(negedge clk);
        start = 1'b0;
        done_seen = 1'b0;
        check("start_busy_done", 64'({busy, done}), 64'(2'b10));
    endtask

    task automatic finish_run();
        int c;
        c = 0;
        while (!done_seen && (c < 20000)) begin
            @(negedge clk);
            c++;
        end
        if (!done_seen) begin
            fail_now("run_timeout");
            reset_flush();
        end else begin
            check("cmds_left", 64'(exp_cmd.size()), 64'd0);
            check("wdata_left", 64'(exp_wd.size()), 64'd0);
            repeat (3) @(negedge clk);
            check("done_held", 64'({done, busy}), 64'(2'b10));
        end
    endtask

    task automatic run(input int m, input bit extra_start, input bit inj);
        begin_run(m, inj);
        if (extra_start) begin
            repeat (40) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        finish_run();
    endtask

    task automatic reset_mid_burst();
        int c;
        begin_run(M_IDEAL, 1'b0);
        c = 0;
        while (!((wr_cmds == 4) && wr_en) && (c < 5000)) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        check("rst_inside_burst", 64'({wr_en, 8'(wr_cmds)}), 64'({1'b1, 8'd4}));
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        flush_model();
        done_seen = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("rst_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle", 64'({busy, done, cmd_en, wr_en}), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        cmd_av = 1'b0;
        rd_av = 1'b0;
        rd_data = '0;
        wr_remain_space = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        flip.delete();
        run(M_IDEAL, 1'b1, 1'b0);
        flip.delete();
        flip[32'h13] = 16'h0008;
        run(M_IDEAL, 1'b0, 1'b0);
        flip.delete();
        run(M_STALL, 1'b0, 1'b0);
        flip.delete();
        run(M_TRICKLE, 1'b0, 1'b0);
        reset_mid_burst();
        flip.delete();
        run(M_IDEAL, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            flip.delete();
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++)
                flip[int'($urandom_range(A0, A1))] = 16'($urandom_range(1, 65535));
            run(M_RANDOM, 1'b0, 1'b0);
        end
`ifdef SDRAM_BIST_ERRINJ_EN
        flip.delete();
        run(M_IDEAL, 1'b0, 1'b1);
        run(M_IDEAL, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
